// File: rtl/unpacked_array_serializer_if.sv
// Port bundle for unpacked_array_serializer: one wide input stream and one narrow output stream.
// Both streams transfer on each rising clk edge where valid and ready are high together.
interface unpacked_array_serializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_NUM     = 16,
  parameter int OUT_NUM    = 4
);
  // Handshake rules:
  // - data_in is sampled only on a transfer. The producer may change it at any other time.
  // - Once data_out_valid rises, data_out_valid, data_out and data_out_last stay stable
  //   until that beat is transferred.
  // - data_in_ready may depend combinationally on data_out_ready.
  logic [DATA_WIDTH-1:0] data_in [IN_NUM];
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic [DATA_WIDTH-1:0] data_out [OUT_NUM];
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic                  data_out_last;
  // FSM state for debug: 0 = IDLE, 1 = SEND.
  logic                  state_dbg;

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, data_out_last, state_dbg
  );

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid, data_out_last, state_dbg
  );
endinterface

// File: rtl/unpacked_array_serializer.sv
// Wide-to-narrow serializer: captures IN_NUM elements per input transfer and sends them
// as IN_NUM/OUT_NUM beats of OUT_NUM elements, lowest indices first.
module unpacked_array_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_NUM     = 16,
  parameter int OUT_NUM    = 4
) (
  input logic                        clk,
  input logic                        rst,
  unpacked_array_serializer_if.slave bus
);
  localparam int BEATS = IN_NUM / OUT_NUM;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [DATA_WIDTH-1:0] buffer_q [IN_NUM];

  logic out_fire;
  logic on_last;
  logic load;
  logic [IDX_W-1:0] idx;

  // Last beat is gated by SEND so that BEATS==1 does not show last while idle.
  assign on_last  = (state_q == SEND) && (cnt_q == LAST_CNT);
  assign out_fire = bus.data_out_valid && bus.data_out_ready;
  assign load     = bus.data_in_valid && bus.data_in_ready;

  assign bus.data_out_valid = (state_q == SEND);
  assign bus.data_out_last  = on_last;
  assign bus.data_in_ready  = (state_q == IDLE) || (on_last && bus.data_out_ready);
  assign bus.state_dbg      = (state_q == SEND);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.data_in_valid) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (out_fire) begin
          if (on_last) begin
            // A new vector accepted on the final beat keeps the stream bubble-free.
            cnt_d   = '0;
            state_d = bus.data_in_valid ? SEND : IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    idx = '0;
    for (int j = 0; j < OUT_NUM; j++) begin
      idx             = IDX_W'(int'(cnt_q) * OUT_NUM + j);
      bus.data_out[j] = buffer_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < IN_NUM; i++) begin
        buffer_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        for (int i = 0; i < IN_NUM; i++) begin
          buffer_q[i] <= bus.data_in[i];
        end
      end
    end
  end

  // A stalled beat must stay put until the consumer takes it.
  a_hold_under_backpressure : assert property (
    @(posedge clk) disable iff (rst)
      (bus.data_out_valid && !bus.data_out_ready) |=>
        (bus.data_out_valid && $stable(cnt_q))
  );

  a_cnt_in_range : assert property (
    @(posedge clk) disable iff (rst) (cnt_q <= LAST_CNT)
  );
endmodule

// File: tb/tb_unpacked_array_serializer.sv
// Bench for unpacked_array_serializer: directed scenarios plus a randomized run checked
// against an element-queue reference model; a second instance covers IN_NUM == OUT_NUM.
module tb_unpacked_array_serializer;
  localparam int DW    = 8;
  localparam int IN_N  = 16;
  localparam int OUT_N = 4;
  localparam int BEATS = IN_N / OUT_N;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  unpacked_array_serializer_if #(.DATA_WIDTH(DW), .IN_NUM(IN_N), .OUT_NUM(OUT_N)) bus ();
  unpacked_array_serializer_if #(.DATA_WIDTH(DW), .IN_NUM(4), .OUT_NUM(4)) bus1 ();

  unpacked_array_serializer #(.DATA_WIDTH(DW), .IN_NUM(IN_N), .OUT_NUM(OUT_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  unpacked_array_serializer #(.DATA_WIDTH(DW), .IN_NUM(4), .OUT_NUM(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Expected element stream: every accepted vector appends its IN_N elements in index order;
  // every accepted beat must consume the next OUT_N of them.
  logic [DW-1:0] exp_q[$];
  int out_beat   = 0;
  int in_total   = 0;
  int last_total = 0;
  int pend;
  logic [OUT_N*DW-1:0] mon_obs;
  logic [OUT_N*DW-1:0] mon_exp;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      out_beat   = 0;
      in_total   = 0;
      last_total = 0;
    end else begin
      pend = exp_q.size() / OUT_N;
      check("mon_valid", bus.data_out_valid, pend > 0);
      check("mon_in_ready", bus.data_in_ready,
            (pend == 0) || (pend == 1 && bus.data_out_ready));
      if (pend > 0) begin
        for (int j = 0; j < OUT_N; j++) begin
          mon_obs[j*DW +: DW] = bus.data_out[j];
          mon_exp[j*DW +: DW] = exp_q[j];
        end
        check("mon_data", mon_obs, mon_exp);
        check("mon_last", bus.data_out_last, out_beat == BEATS - 1);
      end else begin
        check("mon_last_idle", bus.data_out_last, 1'b0);
      end
      if (bus.data_out_valid && bus.data_out_ready && pend > 0) begin
        for (int j = 0; j < OUT_N; j++) void'(exp_q.pop_front());
        if (bus.data_out_last) last_total++;
        out_beat = (out_beat + 1) % BEATS;
      end
      if (bus.data_in_valid && bus.data_in_ready) begin
        for (int i = 0; i < IN_N; i++) exp_q.push_back(bus.data_in[i]);
        in_total++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input int base);
    for (int i = 0; i < IN_N; i++) bus.data_in[i] = DW'(base + i);
  endtask

  task automatic expect_beat(input string tag, input int base, input logic exp_last,
                             input logic exp_rdy);
    logic [OUT_N*DW-1:0] o;
    logic [OUT_N*DW-1:0] e;
    @(negedge clk);
    for (int j = 0; j < OUT_N; j++) begin
      o[j*DW +: DW] = bus.data_out[j];
      e[j*DW +: DW] = DW'(base + j);
    end
    check({tag, "_valid"}, bus.data_out_valid, 1'b1);
    check({tag, "_data"}, o, e);
    check({tag, "_last"}, bus.data_out_last, exp_last);
    check({tag, "_in_ready"}, bus.data_in_ready, exp_rdy);
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, bus.data_out_valid, 1'b0);
    check({tag, "_last"}, bus.data_out_last, 1'b0);
    check({tag, "_in_ready"}, bus.data_in_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  logic [OUT_N*DW-1:0] rst_data;
  logic [4*DW-1:0] prev1;
  int cyc;
  int vec_start;

  initial begin
    rst = 1'b1;
    bus.data_in_valid  = 1'b0;
    bus.data_out_ready = 1'b0;
    bus1.data_in_valid  = 1'b0;
    bus1.data_out_ready = 1'b0;
    load_vec(0);
    for (int i = 0; i < 4; i++) bus1.data_in[i] = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Test 1: reset state, then one vector i with ready held high.
    @(negedge clk);
    for (int j = 0; j < OUT_N; j++) rst_data[j*DW +: DW] = bus.data_out[j];
    check("rst_valid", bus.data_out_valid, 1'b0);
    check("rst_last", bus.data_out_last, 1'b0);
    check("rst_in_ready", bus.data_in_ready, 1'b1);
    check("rst_data", rst_data, '0);
    check("rst_state", bus.state_dbg, 1'b0);
    load_vec(0);
    bus.data_in_valid  = 1'b1;
    bus.data_out_ready = 1'b1;
    tick();
    bus.data_in_valid = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      expect_beat("t1", 4 * b, b == BEATS - 1, b == BEATS - 1);
      tick();
    end
    expect_idle("t1_end");

    // Test 2: two vectors back to back, no bubble between them.
    load_vec(8'h10);
    bus.data_in_valid = 1'b1;
    tick();
    load_vec(8'h20);
    for (int b = 0; b < 2 * BEATS; b++) begin
      expect_beat("t2", ((b < BEATS) ? 8'h10 : 8'h20) + 4 * (b % BEATS),
                  (b % BEATS) == BEATS - 1, (b % BEATS) == BEATS - 1);
      tick();
      if (b == BEATS - 1) bus.data_in_valid = 1'b0;
    end
    expect_idle("t2_end");

    // Test 3: back-pressure on the second beat for 5 cycles.
    load_vec(0);
    bus.data_in_valid = 1'b1;
    tick();
    bus.data_in_valid = 1'b0;
    expect_beat("t3_b0", 0, 1'b0, 1'b0);
    tick();
    bus.data_out_ready = 1'b0;
    repeat (5) begin
      expect_beat("t3_hold", 4, 1'b0, 1'b0);
      tick();
    end
    bus.data_out_ready = 1'b1;
    for (int b = 1; b < BEATS; b++) begin
      expect_beat("t3", 4 * b, b == BEATS - 1, b == BEATS - 1);
      tick();
    end
    expect_idle("t3_end");

    // Test 4: reset right after the first beat is accepted.
    load_vec(0);
    bus.data_in_valid = 1'b1;
    tick();
    bus.data_in_valid = 1'b0;
    expect_beat("t4_b0", 0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_idle("t4_rst");
    load_vec(8'hA0);
    bus.data_in_valid = 1'b1;
    tick();
    bus.data_in_valid = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      expect_beat("t4", 8'hA0 + 4 * b, b == BEATS - 1, b == BEATS - 1);
      tick();
    end
    expect_idle("t4_end");

    // Test 5: random valid/ready toggling, scored by the queue model.
    vec_start = in_total;
    cyc = 0;
    while ((in_total - vec_start) < 1000 && cyc < 20000) begin
      for (int i = 0; i < IN_N; i++) bus.data_in[i] = DW'($urandom);
      bus.data_in_valid  = ($urandom_range(0, 3) != 0);
      bus.data_out_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    check("t5_vec_budget", (in_total - vec_start) >= 1000, 1'b1);
    bus.data_in_valid  = 1'b0;
    bus.data_out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    @(negedge clk);
    check("t5_drain", exp_q.size(), 0);
    check("t5_last_per_vec", last_total, in_total);
    tick();

    // Test 6: IN_NUM == OUT_NUM, one beat per vector at full throughput.
    prev1 = '0;
    bus1.data_out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++) bus1.data_in[i] = DW'($urandom);
      bus1.data_in_valid = 1'b1;
      @(negedge clk);
      check("t6_in_ready", bus1.data_in_ready, 1'b1);
      if (k > 0) begin
        check("t6_valid", bus1.data_out_valid, 1'b1);
        check("t6_last", bus1.data_out_last, 1'b1);
        check("t6_data", {bus1.data_out[3], bus1.data_out[2], bus1.data_out[1],
                          bus1.data_out[0]}, prev1);
      end else begin
        check("t6_idle_valid", bus1.data_out_valid, 1'b0);
      end
      prev1 = {bus1.data_in[3], bus1.data_in[2], bus1.data_in[1], bus1.data_in[0]};
      tick();
    end
    bus1.data_in_valid = 1'b0;
    @(negedge clk);
    check("t6_tail_valid", bus1.data_out_valid, 1'b1);
    check("t6_tail_last", bus1.data_out_last, 1'b1);
    check("t6_tail_data", {bus1.data_out[3], bus1.data_out[2], bus1.data_out[1],
                           bus1.data_out[0]}, prev1);
    tick();
    @(negedge clk);
    check("t6_end_valid", bus1.data_out_valid, 1'b0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
